// File: rtl/serial_adder_ctrl_if.sv
// Request/result bundle between a requester and the serial adder sequencer.
// Operand and result widths follow NIBBLES so both ends agree on W = 4*NIBBLES.
interface serial_adder_ctrl_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic         start;
    logic         sub;
    logic         cin;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ready;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         overflow;

    modport master (
        output start, sub, cin, a, b,
        input  ready, done, sum, cout, overflow
    );

    modport slave (
        input  start, sub, cin, a, b,
        output ready, done, sum, cout, overflow
    );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Wide add/subtract built from one 4-bit adder slice reused over NIBBLES cycles,
// least significant nibble first, with the carry kept in a register between cycles.
module serial_adder_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic               clk,
    input  logic               rst,
    serial_adder_ctrl_if.slave bus
);
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state, state_next;

    logic [NIBBLES-1:0][3:0] opa;
    logic [NIBBLES-1:0][3:0] opb;
    logic [NIBBLES-1:0][3:0] sum_q;
    logic                    carry;
    logic                    cout_q;
    logic                    ovf_q;
    logic [IW-1:0]           idx;

    logic       accept;
    logic       ready;
    logic       done;
    logic [3:0] na;
    logic [3:0] nb;
    logic [4:0] slice_full;
    logic [3:0] slice_sum;
    logic       slice_co;
    logic       carry3;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        ready      = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (idx == LAST) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // The carry into bit 3 is recovered from the sum bit, avoiding a second adder.
    assign na         = opa[idx];
    assign nb         = opb[idx];
    assign slice_full = {1'b0, na} + {1'b0, nb} + {4'b0000, carry};
    assign slice_sum  = slice_full[3:0];
    assign slice_co   = slice_full[4];
    assign carry3     = na[3] ^ nb[3] ^ slice_sum[3];

    always_ff @(posedge clk) begin
        if (rst) begin
            opa    <= '0;
            opb    <= '0;
            sum_q  <= '0;
            carry  <= 1'b0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            idx    <= '0;
        end else if (accept) begin
            // Subtraction is a + ~b + 1, so cin only matters for add.
            opa   <= bus.a;
            opb   <= bus.sub ? ~bus.b : bus.b;
            carry <= bus.sub ? 1'b1 : bus.cin;
            idx   <= '0;
        end else if (state == RUN) begin
            sum_q[idx] <= slice_sum;
            carry      <= slice_co;
            idx        <= idx + IW'(1);
            if (idx == LAST) begin
                cout_q <= slice_co;
                ovf_q  <= carry3 ^ slice_co;
            end
        end
    end

    assign bus.ready    = ready;
    assign bus.done     = done;
    assign bus.sum      = sum_q;
    assign bus.cout     = cout_q;
    assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl: a 4-nibble instance for most scenarios
// and a 1-nibble instance for the degenerate single-slice case.
module tb_serial_adder_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   passed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    serial_adder_ctrl_if #(.NIBBLES(4)) bus4 ();
    serial_adder_ctrl_if #(.NIBBLES(1)) bus1 ();

    serial_adder_ctrl #(.NIBBLES(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
    serial_adder_ctrl #(.NIBBLES(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    // Runs one operation; operands are scrambled right after acceptance.
    task automatic do_op4(input logic [15:0] av, input logic [15:0] bv, input logic sv, input logic cv,
                          output int lat, output int rlow,
                          output logic [15:0] s, output logic co, output logic ov);
        lat = 0; rlow = 0; s = 16'h0; co = 1'b0; ov = 1'b0;
        @(negedge clk);
        bus4.a = av; bus4.b = bv; bus4.sub = sv; bus4.cin = cv; bus4.start = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 1) begin
                bus4.start = 1'b0;
                bus4.a = ~av; bus4.b = ~bv; bus4.sub = ~sv; bus4.cin = ~cv;
            end
            if (!bus4.ready) rlow++;
            if (bus4.done && lat == 0) begin
                lat = i; s = bus4.sum; co = bus4.cout; ov = bus4.overflow;
            end
            if (lat != 0 && bus4.ready) break;
        end
    endtask

    task automatic do_op1(input logic [3:0] av, input logic [3:0] bv, input logic cv,
                          output int lat, output logic [3:0] s, output logic co, output logic ov);
        lat = 0; s = 4'h0; co = 1'b0; ov = 1'b0;
        @(negedge clk);
        bus1.a = av; bus1.b = bv; bus1.sub = 1'b0; bus1.cin = cv; bus1.start = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 1) begin
                bus1.start = 1'b0; bus1.a = ~av; bus1.b = ~bv;
            end
            if (bus1.done && lat == 0) begin
                lat = i; s = bus1.sum; co = bus1.cout; ov = bus1.overflow;
            end
            if (lat != 0 && bus1.ready) break;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus4.start = 1'b1; bus4.a = 16'hAAAA; bus4.b = 16'h5555;
        bus1.start = 1'b1; bus1.a = 4'hA; bus1.b = 4'h5;
        repeat (2) @(negedge clk);
        total++; if (bus4.ready !== 1'b1) $display("[TB] FAIL reset_ready: got %b expected 1", bus4.ready); else passed++;
        total++; if (bus4.done !== 1'b0) $display("[TB] FAIL reset_done: got %b expected 0", bus4.done); else passed++;
        total++; if (bus4.sum !== 16'h0) $display("[TB] FAIL reset_sum: got %h expected 0000", bus4.sum); else passed++;
        total++; if ({bus4.cout, bus4.overflow} !== 2'b00) $display("[TB] FAIL reset_flags: got %b expected 00", {bus4.cout, bus4.overflow}); else passed++;
        total++; if (bus1.ready !== 1'b1 || bus1.sum !== 4'h0) $display("[TB] FAIL reset_n1: got ready=%b sum=%h expected 1 0", bus1.ready, bus1.sum); else passed++;
        rst = 1'b0; bus4.start = 1'b0; bus1.start = 1'b0;
        @(negedge clk);
        total++; if (bus4.ready !== 1'b1) $display("[TB] FAIL reset_idle_after: got %b expected 1", bus4.ready); else passed++;
    endtask

    task automatic test_add_basic();
        int lat, rlow; logic [15:0] s; logic co, ov;
        do_op4(16'h1234, 16'h0FCC, 1'b0, 1'b0, lat, rlow, s, co, ov);
        total++; if (lat !== 5) $display("[TB] FAIL add_latency: got %0d expected 5", lat); else passed++;
        total++; if (rlow !== 5) $display("[TB] FAIL add_ready_low: got %0d expected 5", rlow); else passed++;
        total++; if (s !== 16'h2200) $display("[TB] FAIL add_sum: got %h expected 2200", s); else passed++;
        total++; if ({co, ov} !== 2'b00) $display("[TB] FAIL add_flags: got %b expected 00", {co, ov}); else passed++;
    endtask

    task automatic test_add_edges();
        int lat, rlow; logic [15:0] s; logic co, ov;
        do_op4(16'h7FFF, 16'h0001, 1'b0, 1'b0, lat, rlow, s, co, ov);
        total++; if (s !== 16'h8000) $display("[TB] FAIL ovf_sum: got %h expected 8000", s); else passed++;
        total++; if ({co, ov} !== 2'b01) $display("[TB] FAIL ovf_flags: got %b expected 01", {co, ov}); else passed++;
        repeat (3) @(negedge clk);
        total++; if (bus4.sum !== 16'h8000 || {bus4.cout, bus4.overflow} !== 2'b01)
            $display("[TB] FAIL result_hold: got %h/%b expected 8000/01", bus4.sum, {bus4.cout, bus4.overflow}); else passed++;
        do_op4(16'hFFFF, 16'h0000, 1'b0, 1'b1, lat, rlow, s, co, ov);
        total++; if (s !== 16'h0000) $display("[TB] FAIL cin_sum: got %h expected 0000", s); else passed++;
        total++; if ({co, ov} !== 2'b10) $display("[TB] FAIL cin_flags: got %b expected 10", {co, ov}); else passed++;
    endtask

    task automatic test_sub();
        int lat, rlow; logic [15:0] s; logic co, ov;
        do_op4(16'h0005, 16'h0007, 1'b1, 1'b1, lat, rlow, s, co, ov);
        total++; if (s !== 16'hFFFE) $display("[TB] FAIL sub_sum: got %h expected fffe", s); else passed++;
        total++; if ({co, ov} !== 2'b00) $display("[TB] FAIL sub_flags: got %b expected 00", {co, ov}); else passed++;
        do_op4(16'h8000, 16'h0001, 1'b1, 1'b0, lat, rlow, s, co, ov);
        total++; if (s !== 16'h7FFF) $display("[TB] FAIL sub_ovf_sum: got %h expected 7fff", s); else passed++;
        total++; if ({co, ov} !== 2'b11) $display("[TB] FAIL sub_ovf_flags: got %b expected 11", {co, ov}); else passed++;
    endtask

    task automatic test_nibbles1();
        logic [3:0] av [3] = '{4'h9, 4'hC, 4'h8};
        logic [3:0] bv [3] = '{4'hC, 4'h9, 4'h8};
        logic       cv [3] = '{1'b0, 1'b1, 1'b1};
        logic [3:0] ex [3] = '{4'h5, 4'h6, 4'h1};
        int lat; logic [3:0] s; logic co, ov;
        for (int k = 0; k < 3; k++) begin
            do_op1(av[k], bv[k], cv[k], lat, s, co, ov);
            total++; if (lat !== 2) $display("[TB] FAIL n1_latency[%0d]: got %0d expected 2", k, lat); else passed++;
            total++; if (s !== ex[k]) $display("[TB] FAIL n1_sum[%0d]: got %h expected %h", k, s, ex[k]); else passed++;
            total++; if ({co, ov} !== 2'b11) $display("[TB] FAIL n1_flags[%0d]: got %b expected 11", k, {co, ov}); else passed++;
        end
    endtask

    task automatic test_ignore_start();
        @(negedge clk);
        bus4.a = 16'h1234; bus4.b = 16'h0FCC; bus4.sub = 1'b0; bus4.cin = 1'b0; bus4.start = 1'b1;
        @(negedge clk);
        bus4.start = 1'b0; bus4.a = 16'hFFFF; bus4.b = 16'hFFFF; bus4.sub = 1'b1;
        @(negedge clk);
        bus4.start = 1'b1;
        @(negedge clk);
        bus4.start = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (bus4.done !== 1'b1 || bus4.sum !== 16'h2200)
            $display("[TB] FAIL ignore_run_result: got done=%b sum=%h expected 1 2200", bus4.done, bus4.sum); else passed++;
        bus4.start = 1'b1;
        @(negedge clk);
        bus4.start = 1'b0;
        total++; if (bus4.ready !== 1'b1) $display("[TB] FAIL ignore_done_ready: got %b expected 1", bus4.ready); else passed++;
        @(negedge clk);
        total++; if (bus4.ready !== 1'b1 || bus4.done !== 1'b0 || bus4.sum !== 16'h2200)
            $display("[TB] FAIL ignore_done_start: got ready=%b done=%b sum=%h expected 1 0 2200", bus4.ready, bus4.done, bus4.sum); else passed++;
    endtask

    task automatic test_back_to_back();
        int d1 = 0, d2 = 0;
        logic [15:0] s2 = 16'h0;
        @(negedge clk);
        bus4.a = 16'h0001; bus4.b = 16'h0002; bus4.sub = 1'b0; bus4.cin = 1'b0; bus4.start = 1'b1;
        for (int i = 1; i <= 18; i++) begin
            @(negedge clk);
            if (bus4.done) begin
                if (d1 == 0) d1 = i;
                else if (d2 == 0) begin d2 = i; s2 = bus4.sum; end
            end
        end
        bus4.start = 1'b0;
        total++; if (d1 !== 5) $display("[TB] FAIL b2b_first_done: got %0d expected 5", d1); else passed++;
        total++; if (d2 - d1 !== 6) $display("[TB] FAIL b2b_spacing: got %0d expected 6", d2 - d1); else passed++;
        total++; if (s2 !== 16'h0003) $display("[TB] FAIL b2b_sum: got %h expected 0003", s2); else passed++;
        for (int i = 0; i < 20 && !bus4.ready; i++) @(negedge clk);
        total++; if (bus4.ready !== 1'b1) $display("[TB] FAIL b2b_idle: got %b expected 1", bus4.ready); else passed++;
    endtask

    task automatic test_reset_mid_run();
        int lat, rlow, ndone; logic [15:0] s; logic co, ov;
        @(negedge clk);
        bus4.a = 16'h1111; bus4.b = 16'h2222; bus4.sub = 1'b0; bus4.cin = 1'b0; bus4.start = 1'b1;
        @(negedge clk);
        bus4.start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++; if (bus4.ready !== 1'b1 || bus4.done !== 1'b0)
            $display("[TB] FAIL abort_ctrl: got ready=%b done=%b expected 1 0", bus4.ready, bus4.done); else passed++;
        total++; if (bus4.sum !== 16'h0 || {bus4.cout, bus4.overflow} !== 2'b00)
            $display("[TB] FAIL abort_outputs: got %h/%b expected 0000/00", bus4.sum, {bus4.cout, bus4.overflow}); else passed++;
        ndone = 0;
        repeat (6) begin @(negedge clk); if (bus4.done) ndone++; end
        total++; if (ndone !== 0) $display("[TB] FAIL abort_no_done: got %0d pulses expected 0", ndone); else passed++;
        do_op4(16'h0001, 16'h0001, 1'b0, 1'b0, lat, rlow, s, co, ov);
        total++; if (s !== 16'h0002 || lat !== 5) $display("[TB] FAIL after_abort: got sum=%h lat=%0d expected 0002 5", s, lat); else passed++;
    endtask

    initial begin
        bus4.start = 1'b0; bus4.sub = 1'b0; bus4.cin = 1'b0; bus4.a = '0; bus4.b = '0;
        bus1.start = 1'b0; bus1.sub = 1'b0; bus1.cin = 1'b0; bus1.a = '0; bus1.b = '0;
        test_reset();
        test_add_basic();
        test_add_edges();
        test_sub();
        test_nibbles1();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
